// File: rtl/fp_widen_unit_if.sv
// ---------------------------------------------------------------------------
// fp_widen_unit_if
//   Handshake bundle between the FPU issue stage, the widening converter and
//   the writeback/result FIFO.
//
//   in_valid / in_ready   request handshake (issue side)
//   in_data  [31:0]       operand: FP32 bits or 32-bit integer
//   in_type  [1:0]        00 FP32, 10 INT32, 11 UINT32, 01 illegal
//   out_valid / out_ready result handshake (writeback side)
//   out_data [63:0]       FP64 result
//   out_flag_invalid      sNaN source or illegal in_type, qualified by out_valid
//
//   master: the requester/consumer side (issue stage + result FIFO)
//   slave : the converter itself
// ---------------------------------------------------------------------------
interface fp_widen_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_type;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_flag_invalid;

  modport master (
    output in_valid, in_data, in_type, out_ready,
    input  in_ready, out_valid, out_data, out_flag_invalid
  );

  modport slave (
    input  in_valid, in_data, in_type, out_ready,
    output in_ready, out_valid, out_data, out_flag_invalid
  );
endinterface

// File: rtl/fp_widen_unit.sv
// ---------------------------------------------------------------------------
// fp_widen_unit
//   Multi-cycle exact widening converter: FP32 / INT32 / UINT32 -> FP64.
//   Every result is exact, so there is no rounding and no inexact/overflow/
//   underflow signalling. FP32 denormals and integers are normalised by
//   stripping leading zeros, up to SHIFT_STEP bits per cycle.
//
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-high reset
//     bus  fp_widen_unit_if.slave (request and result handshakes)
//
//   Parameter:
//     SHIFT_STEP  maximum left shift per normalisation cycle (1, 2, 4 or 8)
// ---------------------------------------------------------------------------
module fp_widen_unit #(
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  fp_widen_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  localparam logic [11:0] E_FP_DENORM = 12'd896;   // 1023 - 127
  localparam logic [11:0] E_INT       = 12'd1054;  // 1023 + 31
  localparam logic [63:0] QNAN64      = 64'h7FF8_0000_0000_0000;

  state_t      state_q, state_d;
  logic [31:0] w_q, w_d;        // working magnitude, binary point below bit 31
  logic [11:0] e_q, e_d;        // biased FP64 exponent of w[31]
  logic        sign_q, sign_d;
  logic [63:0] data_q, data_d;
  logic        inv_q, inv_d;

  // Capture-path decode of the incoming operand.
  logic        fp_sign;
  logic [7:0]  fp_exp;
  logic [22:0] fp_frac;
  logic [10:0] fp_exp_wide;
  logic [31:0] int_mag;
  logic        accept;

  logic        cap_norm;        // result comes from the w/E normalisation path
  logic [31:0] cap_w;
  logic [11:0] cap_e;
  logic        cap_sign;
  logic [63:0] cap_data;        // direct result for the non-normalising cases
  logic        cap_inv;

  function automatic logic [63:0] assemble(input logic s,
                                           input logic [10:0] e,
                                           input logic [30:0] m);
    return {s, e, m, 21'b0};
  endfunction

  assign bus.in_ready         = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign bus.out_valid        = (state_q == DONE);
  assign bus.out_data         = data_q;
  assign bus.out_flag_invalid = inv_q;

  assign accept = bus.in_valid & bus.in_ready;

  assign fp_sign     = bus.in_data[31];
  assign fp_exp      = bus.in_data[30:23];
  assign fp_frac     = bus.in_data[22:0];
  assign fp_exp_wide = {3'b000, fp_exp} + 11'd896;

  // Two's-complement magnitude for INT32; 0x80000000 maps onto itself, which
  // is exactly the unsigned magnitude 2^31. UINT32 passes straight through.
  assign int_mag = (~bus.in_type[0] & bus.in_data[31]) ? (~bus.in_data + 32'd1)
                                                      : bus.in_data;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    cap_norm = 1'b0;
    cap_w    = '0;
    cap_e    = '0;
    cap_sign = 1'b0;
    cap_data = '0;
    cap_inv  = 1'b0;

    case (bus.in_type)
      2'b00: begin
        if (fp_exp == 8'hFF) begin
          if (fp_frac == '0) begin
            cap_data = {fp_sign, 11'h7FF, 52'b0};
          end else begin
            // Quiet the NaN, keep the payload; only a signalling source flags.
            cap_data = {fp_sign, 11'h7FF, 1'b1, fp_frac[21:0], 29'b0};
            cap_inv  = ~fp_frac[22];
          end
        end else if (fp_exp != 8'h00) begin
          cap_data = {fp_sign, fp_exp_wide, fp_frac, 29'b0};
        end else if (fp_frac == '0) begin
          cap_data = {fp_sign, 63'b0};
        end else begin
          cap_norm = 1'b1;
          cap_sign = fp_sign;
          cap_w    = {fp_frac, 9'b0};
          cap_e    = E_FP_DENORM;
        end
      end
      2'b10, 2'b11: begin
        if (bus.in_data != '0) begin
          cap_norm = 1'b1;
          cap_sign = ~bus.in_type[0] & bus.in_data[31];
          cap_w    = int_mag;
          cap_e    = E_INT;
        end
      end
      default: begin
        cap_data = QNAN64;
        cap_inv  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    e_d     = e_q;
    sign_d  = sign_q;
    data_d  = data_q;
    inv_d   = inv_q;

    case (state_q)
      NORM: begin
        // Jump a whole step while the top SHIFT_STEP bits are clear; that can
        // never push the leading one out. Otherwise creep one bit at a time.
        if (w_q[31 -: SHIFT_STEP] == '0) begin
          w_d = w_q << SHIFT_STEP;
          e_d = e_q - 12'(SHIFT_STEP);
        end else begin
          w_d = w_q << 1;
          e_d = e_q - 12'd1;
        end
        if (w_d[31]) begin
          state_d = DONE;
          data_d  = assemble(sign_q, e_d[10:0], w_d[30:0]);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: ;
    endcase

    // Acceptance is only possible from IDLE or a draining DONE, so it never
    // collides with a NORM step.
    if (accept) begin
      sign_d = cap_sign;
      w_d    = cap_w;
      e_d    = cap_e;
      inv_d  = cap_inv;
      if (!cap_norm) begin
        state_d = DONE;
        data_d  = cap_data;
      end else if (cap_w[31]) begin
        state_d = DONE;
        data_d  = assemble(cap_sign, cap_e[10:0], cap_w[30:0]);
      end else begin
        state_d = NORM;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
    end
  end

endmodule

// File: tb/tb_fp_widen_unit.sv
// ---------------------------------------------------------------------------
// tb_fp_widen_unit
//   Self-checking bench for fp_widen_unit. Two instances (SHIFT_STEP 4 and 1)
//   are exercised with a directed vector table, hand-written backpressure and
//   reset sequences, and randomized operands compared against a numeric model.
// ---------------------------------------------------------------------------
module tb_fp_widen_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fp_widen_unit_if bus4 ();
  fp_widen_unit_if bus1 ();

  fp_widen_unit #(.SHIFT_STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  fp_widen_unit #(.SHIFT_STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          which;     // 0: SHIFT_STEP=4 instance, 1: SHIFT_STEP=1 instance
    logic [31:0] d;
    logic [1:0]  t;
    logic [63:0] exp_data;
    logic        exp_inv;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_in(input int which, input logic v, input logic [31:0] d,
                        input logic [1:0] t, input logic ordy);
    if (which == 0) begin
      bus4.in_valid = v; bus4.in_data = d; bus4.in_type = t; bus4.out_ready = ordy;
    end else begin
      bus1.in_valid = v; bus1.in_data = d; bus1.in_type = t; bus1.out_ready = ordy;
    end
  endtask

  task automatic get_out(input int which, output logic ov, output logic ir,
                         output logic [63:0] od, output logic oi);
    if (which == 0) begin
      ov = bus4.out_valid; ir = bus4.in_ready; od = bus4.out_data; oi = bus4.out_flag_invalid;
    end else begin
      ov = bus1.out_valid; ir = bus1.in_ready; od = bus1.out_data; oi = bus1.out_flag_invalid;
    end
  endtask

  // Issue one operand with out_ready=1 and wait (bounded) for the result.
  // lat counts clock edges from the accept edge to the first valid sample.
  task automatic do_op(input int which, input logic [31:0] d, input logic [1:0] t,
                       output logic [63:0] res, output logic inv, output int lat,
                       output logic busy_ok);
    logic ov, ir, oi;
    logic [63:0] od;
    set_in(which, 1'b1, d, t, 1'b1);
    @(posedge clk); #1;
    set_in(which, 1'b0, $urandom, 2'($urandom), 1'b1);
    lat = 1;
    busy_ok = 1'b1;
    get_out(which, ov, ir, od, oi);
    while (!ov && lat < 64) begin
      if (ir) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
      get_out(which, ov, ir, od, oi);
    end
    res = od;
    inv = oi;
  endtask

  function automatic int msb_pos(input logic [63:0] v);
    int p = -1;
    for (int i = 0; i < 64; i++) if (v[i]) p = i;
    return p;
  endfunction

  // Numeric reference: derive the FP64 encoding from the operand's value,
  // and latency from the leading-zero distance and the shift step.
  task automatic ref_model(input logic [31:0] d, input logic [1:0] t, input int step,
                           output logic [63:0] data, output logic inv, output int lat);
    logic        s;
    int          e, p, k, ex;
    logic [22:0] f;
    logic [63:0] m, sh;
    inv = 1'b0;
    lat = 1;
    data = '0;
    k = 0;
    if (t == 2'b01) begin
      data = 64'h7FF8_0000_0000_0000;
      inv  = 1'b1;
    end else if (t == 2'b00) begin
      s = d[31];
      e = int'(d[30:23]);
      f = d[22:0];
      if (e == 255) begin
        if (f == '0) data = {s, 11'h7FF, 52'b0};
        else begin
          data = {s, 11'h7FF, 1'b1, f[21:0], 29'b0};
          inv  = ~f[22];
        end
      end else if (e != 0) begin
        ex   = e - 127 + 1023;
        data = {s, 11'(ex), f, 29'b0};
      end else if (f == '0) begin
        data = {s, 63'b0};
      end else begin
        // value = f * 2^-149
        m    = 64'(f);
        p    = msb_pos(m);
        sh   = m << (52 - p);
        ex   = 1023 + p - 149;
        data = {s, 11'(ex), sh[51:0]};
        k    = 22 - p;
      end
    end else begin
      s = (t == 2'b10) && d[31];
      m = s ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
      if (m != '0) begin
        p    = msb_pos(m);
        sh   = m << (52 - p);
        ex   = 1023 + p;
        data = {s, 11'(ex), sh[51:0]};
        k    = 31 - p;
      end
    end
    lat = 1 + k / step + k % step;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[$];
    logic [63:0] res, exp_d, hold;
    logic        inv, exp_i, busy_ok, stable, ready_low, seen;
    int          lat, exp_l;

    set_in(0, 1'b0, '0, 2'b00, 1'b1);
    set_in(1, 1'b0, '0, 2'b00, 1'b1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid4", 64'(bus4.out_valid), 64'd0);
    check("rst_out_data4",  bus4.out_data, 64'd0);
    check("rst_inv4",       64'(bus4.out_flag_invalid), 64'd0);
    check("rst_in_ready4",  64'(bus4.in_ready), 64'd1);
    check("rst_out_data1",  bus1.out_data, 64'd0);
    check("rst_in_ready1",  64'(bus1.in_ready), 64'd1);

    // ---------------- directed vector table ----------------
    tbl.push_back('{0, 32'h3F80_0000, 2'b00, 64'h3FF0_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{1, 32'h0000_0001, 2'b00, 64'h36A0_0000_0000_0000, 1'b0, 23});
    tbl.push_back('{0, 32'h0000_0001, 2'b00, 64'h36A0_0000_0000_0000, 1'b0, 8});
    tbl.push_back('{0, 32'h807F_FFFF, 2'b00, 64'hB80F_FFFF_C000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'h0080_0000, 2'b00, 64'h3810_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'h7F7F_FFFF, 2'b00, 64'h47EF_FFFF_E000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'h8000_0000, 2'b00, 64'h8000_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'hFFFF_FFFF, 2'b10, 64'hBFF0_0000_0000_0000, 1'b0, 11});
    tbl.push_back('{1, 32'hFFFF_FFFF, 2'b10, 64'hBFF0_0000_0000_0000, 1'b0, 32});
    tbl.push_back('{0, 32'hFFFF_FFFD, 2'b10, 64'hC008_0000_0000_0000, 1'b0, 10});
    tbl.push_back('{0, 32'h8000_0000, 2'b10, 64'hC1E0_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'h0000_0000, 2'b10, 64'h0000_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'hFFFF_FFFF, 2'b11, 64'h41EF_FFFF_FFE0_0000, 1'b0, 1});
    tbl.push_back('{1, 32'h0000_0001, 2'b11, 64'h3FF0_0000_0000_0000, 1'b0, 32});
    tbl.push_back('{0, 32'h7F80_0001, 2'b00, 64'h7FF8_0000_2000_0000, 1'b1, 1});
    tbl.push_back('{0, 32'hFFC0_0001, 2'b00, 64'hFFF8_0000_2000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'hFF80_0000, 2'b00, 64'hFFF0_0000_0000_0000, 1'b0, 1});
    tbl.push_back('{0, 32'h1234_5678, 2'b01, 64'h7FF8_0000_0000_0000, 1'b1, 1});

    foreach (tbl[i]) begin
      do_op(tbl[i].which, tbl[i].d, tbl[i].t, res, inv, lat, busy_ok);
      check($sformatf("tbl%0d_data", i), res, tbl[i].exp_data);
      check($sformatf("tbl%0d_inv", i), 64'(inv), 64'(tbl[i].exp_inv));
      check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("tbl%0d_busy_ready", i), 64'(busy_ok), 64'd1);
    end

    // ---------------- backpressure, then no-bubble reissue ----------------
    @(posedge clk); #1;
    set_in(0, 1'b1, 32'h3F80_0000, 2'b00, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 32'hDEAD_BEEF, 2'b10, 1'b0);
    check("bp_valid", 64'(bus4.out_valid), 64'd1);
    check("bp_data", bus4.out_data, 64'h3FF0_0000_0000_0000);
    hold = 64'h3FF0_0000_0000_0000;
    stable = 1'b1;
    ready_low = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus4.out_data !== hold || bus4.out_valid !== 1'b1) stable = 1'b0;
      if (bus4.in_ready !== 1'b0) ready_low = 1'b0;
    end
    check("bp_stable", 64'(stable), 64'd1);
    check("bp_in_ready_low", 64'(ready_low), 64'd1);
    set_in(0, 1'b1, 32'h4000_0000, 2'b00, 1'b1);
    #1;
    check("bp_in_ready_rise", 64'(bus4.in_ready), 64'd1);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, 2'b00, 1'b1);
    check("b2b_valid", 64'(bus4.out_valid), 64'd1);
    check("b2b_data", bus4.out_data, 64'h4000_0000_0000_0000);

    // ---------------- reset in the middle of NORM ----------------
    @(posedge clk); #1;
    set_in(0, 1'b1, 32'h0000_0001, 2'b10, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, '0, 2'b00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("mid_norm_busy", 64'(bus4.in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_out_valid", 64'(bus4.out_valid), 64'd0);
    check("mrst_out_data", bus4.out_data, 64'd0);
    check("mrst_in_ready", 64'(bus4.in_ready), 64'd1);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus4.out_valid) seen = 1'b1;
    end
    check("mrst_no_stale", 64'(seen), 64'd0);

    // ---------------- randomized operands vs numeric model ----------------
    for (int n = 0; n < 300; n++) begin
      int          which, cat;
      logic [31:0] d;
      logic [1:0]  t;
      which = int'($urandom_range(0, 1));
      cat   = int'($urandom_range(0, 5));
      d     = $urandom;
      case (cat)
        0: t = 2'b00;
        1: begin t = 2'b00; d[30:23] = 8'h00; d[22:0] = d[22:0] >> $urandom_range(0, 22); end
        2: begin t = 2'b00; d[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) d[22:0] = '0; end
        3: begin t = 2'b10; d = d >> $urandom_range(0, 31); if ($urandom_range(0, 1) == 1) d = ~d; end
        4: begin t = 2'b11; d = d >> $urandom_range(0, 31); end
        default: t = 2'b01;
      endcase
      ref_model(d, t, (which == 0) ? 4 : 1, exp_d, exp_i, exp_l);
      do_op(which, d, t, res, inv, lat, busy_ok);
      check($sformatf("rnd%0d_data(d=%h t=%b)", n, d, t), res, exp_d);
      check($sformatf("rnd%0d_inv", n), 64'(inv), 64'(exp_i));
      check($sformatf("rnd%0d_lat", n), 64'(lat), 64'(exp_l));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
